// File: rtl/gpu_pkg.sv
// Shared display-pipeline types and constants.
package gpu_pkg;

  localparam int unsigned H_RES      = 640;
  localparam int unsigned V_RES      = 480;
  localparam int unsigned NUM_PIXELS = H_RES * V_RES;
  localparam int unsigned PIX_ADDR_W = 19;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/frame_scanout_reader_if.sv
// Framebuffer read port plus pixel stream to the display sink.
interface frame_scanout_reader_if #(
  parameter int unsigned ADDR_W = 19
);

  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_r;
  logic [7:0]        mem_g;
  logic [7:0]        mem_b;

  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_r;
  logic [7:0]        out_g;
  logic [7:0]        out_b;
  logic [ADDR_W-1:0] out_pixel_number;
  logic              out_last;

  modport master (
    output mem_read, mem_addr,
    input  mem_r, mem_g, mem_b,
    output out_valid, out_r, out_g, out_b, out_pixel_number, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_read, mem_addr,
    output mem_r, mem_g, mem_b,
    input  out_valid, out_r, out_g, out_b, out_pixel_number, out_last,
    output out_ready
  );

endinterface

// File: rtl/scanout_fifo.sv
// Show-ahead return buffer; the head entry is visible while valid.
module scanout_fifo #(
  parameter int unsigned WIDTH = 43,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign valid  = (count != '0);
  assign rdata  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/frame_scanout_reader.sv
// Walks the framebuffer once per frame_ready and streams pixels to the display.
module frame_scanout_reader #(
  parameter int unsigned NUM_PIXELS   = gpu_pkg::NUM_PIXELS,
  parameter int unsigned ADDR_W       = gpu_pkg::PIX_ADDR_W,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_ready,
  frame_scanout_reader_if.master        bus,
  output logic                          busy,
  output logic                          frame_done
);

  import gpu_pkg::*;

  localparam int unsigned ENTRY_W   = ADDR_W + 24;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CRED_W    = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  scan_state_t             state;
  logic                    pending;
  logic [ADDR_W-1:0]       addr;
  logic [ADDR_W-1:0]       ret_addr;
  logic [READ_LATENCY-1:0] inflight;
  logic [CRED_W-1:0]       credit;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_valid;
  logic [ENTRY_W-1:0]      fifo_rdata;
  logic [ADDR_W-1:0]       head_addr;
  rgb_t                    head_pix;
  rgb_t                    mem_pix;

  // Issue only while every outstanding read still has a guaranteed FIFO slot.
  always_comb begin
    credit = CRED_W'(fifo_count);
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      credit = credit + CRED_W'(inflight[i]);
    end
    issue = (state == SCAN) && (credit < CRED_W'(FIFO_DEPTH));
  end

  assign push    = inflight[READ_LATENCY-1];
  assign pop     = fifo_valid && bus.out_ready;
  assign mem_pix = '{r: bus.mem_r, g: bus.mem_g, b: bus.mem_b};

  // Frame sequencing, address generation and in-flight read tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pending  <= 1'b0;
      addr     <= '0;
      ret_addr <= '0;
      inflight <= '0;
    end else begin
      inflight <= (inflight << 1) | READ_LATENCY'(issue);
      if (push) ret_addr <= ret_addr + ADDR_W'(1);
      unique case (state)
        IDLE: begin
          if (frame_ready) state <= SCAN;
        end
        SCAN: begin
          if (frame_ready) pending <= 1'b1;
          if (issue) begin
            if (addr == LAST_ADDR) state <= DRAIN;
            else                   addr  <= addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (frame_ready) pending <= 1'b1;
          // Reads return in order, so accepting the last pixel empties the pipe.
          if (pop && (head_addr == LAST_ADDR)) state <= DONE;
        end
        DONE: begin
          addr     <= '0;
          ret_addr <= '0;
          pending  <= 1'b0;
          state    <= (pending || frame_ready) ? SCAN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  scanout_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .wdata ({ret_addr, mem_pix}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign {head_addr, head_pix} = fifo_rdata;

  assign bus.mem_read         = issue;
  assign bus.mem_addr         = addr;
  assign bus.out_valid        = fifo_valid;
  assign bus.out_r            = fifo_valid ? head_pix.r : 8'd0;
  assign bus.out_g            = fifo_valid ? head_pix.g : 8'd0;
  assign bus.out_b            = fifo_valid ? head_pix.b : 8'd0;
  assign bus.out_pixel_number = fifo_valid ? head_addr : '0;
  assign bus.out_last         = fifo_valid && (head_addr == LAST_ADDR);
  assign busy                 = (state != IDLE);
  assign frame_done           = (state == DONE);

endmodule

// File: tb/tb_frame_scanout_reader.sv
// Scoreboard bench for frame_scanout_reader with a fixed-latency memory model.
module tb_frame_scanout_reader;

  localparam int unsigned NP = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned RL = 2;
  localparam int unsigned FD = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_ready = 1'b0;
  logic busy;
  logic frame_done;

  frame_scanout_reader_if #(.ADDR_W(AW)) bus ();

  frame_scanout_reader #(
    .NUM_PIXELS   (NP),
    .ADDR_W       (AW),
    .READ_LATENCY (RL),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_ready (frame_ready),
    .bus         (bus.master),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  initial forever #5 clk = ~clk;

  // Memory model: data for an address appears RL edges after the strobe is sampled.
  logic [AW-1:0] pipe_a [RL];
  always @(posedge clk) begin
    pipe_a[0] <= bus.mem_addr;
    for (int i = 1; i < RL; i++) pipe_a[i] <= pipe_a[i-1];
  end
  assign bus.mem_r = 8'(pipe_a[RL-1]);
  assign bus.mem_g = 8'(pipe_a[RL-1]) + 8'd16;
  assign bus.mem_b = 8'd255 - 8'(pipe_a[RL-1]);

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int issued = 0;
  int accepted = 0;
  int max_out = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < int'(NP); i++) begin
      e.a    = AW'(i);
      e.r    = 8'(i);
      e.g    = 8'(i + 16);
      e.b    = 8'(255 - i);
      e.last = (i == int'(NP) - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 400);
    check(name, 32'(frame_done), 32'd1);
  endtask

  task automatic pulse_frame();
    frame_ready = 1'b1;
    @(posedge clk);
    #1 frame_ready = 1'b0;
  endtask

  // Monitor: pops expected pixels on each handshake and checks hold-under-stall.
  initial begin
    exp_t          e;
    logic          stalled;
    logic [31:0]   prev;
    int            outstanding;
    stalled = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        issued = 0;
        accepted = 0;
        stalled = 1'b0;
      end else begin
        outstanding = issued - accepted + (bus.mem_read ? 1 : 0);
        if (outstanding > max_out) max_out = outstanding;
        if (bus.mem_read) issued++;
        if (frame_done) done_cnt++;
        if (stalled) begin
          check("hold_valid", 32'(bus.out_valid), 32'd1);
          check("hold_pixel", {bus.out_pixel_number, bus.out_r, bus.out_g, bus.out_b}, prev);
        end
        stalled = 1'b0;
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pixel: got pixel %0d expected none", bus.out_pixel_number);
          end else if (bus.out_ready) begin
            e = exp_q.pop_front();
            check("pixel_number", 32'(bus.out_pixel_number), 32'(e.a));
            check("pixel_r", 32'(bus.out_r), 32'(e.r));
            check("pixel_g", 32'(bus.out_g), 32'(e.g));
            check("pixel_b", 32'(bus.out_b), 32'(e.b));
            check("pixel_last", 32'(bus.out_last), 32'(e.last));
            accepted++;
          end else begin
            stalled = 1'b1;
            prev = {bus.out_pixel_number, bus.out_r, bus.out_g, bus.out_b};
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int run;
    int iss0;
    int d0;
    bus.out_ready = 1'b0;

    // Reset held for three cycles with a frame_ready pulse that must be ignored.
    #1 reset = 1'b0;
    @(posedge clk);
    #1 frame_ready = 1'b1;
    @(posedge clk);
    #1 frame_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_out_pix", 32'(bus.out_pixel_number), 32'd0);
    check("rst_out_rgb", {8'd0, bus.out_r, bus.out_g, bus.out_b}, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_stays_idle", 32'(busy), 32'd0);

    // Free-running sink.
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    push_frame();
    pulse_frame();
    @(negedge clk);
    check("first_mem_read", 32'(bus.mem_read), 32'd1);
    check("first_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("scan_busy", 32'(busy), 32'd1);
    k = 1;
    while (!bus.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("first_valid_latency", 32'(k - 1), 32'd3);
    run = 0;
    for (int i = 0; i < int'(NP); i++) begin
      if (bus.out_valid) run++;
      @(negedge clk);
    end
    check("stream_run", 32'(run), 32'd8);
    check("done_pulse", 32'(frame_done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(frame_done), 32'd0);
    check("busy_falls", 32'(busy), 32'd0);

    // Sink stalled from the start: exactly FIFO_DEPTH reads, head held on pixel 0.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    iss0 = issued;
    push_frame();
    pulse_frame();
    repeat (12) @(negedge clk);
    check("bp_issue_count", 32'(issued - iss0), 32'd4);
    check("bp_mem_read_off", 32'(bus.mem_read), 32'd0);
    check("bp_valid_held", 32'(bus.out_valid), 32'd1);
    check("bp_head_pixel", 32'(bus.out_pixel_number), 32'd0);
    repeat (4) @(negedge clk);
    check("bp_head_stable", 32'(bus.out_pixel_number), 32'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_done("bp_done");
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Three frames with a seeded random sink.
    k = int'($urandom(32'd2024));
    for (int f = 0; f < 3; f++) begin
      @(posedge clk);
      #1;
      push_frame();
      pulse_frame();
      run = 0;
      do begin
        @(posedge clk);
        #1 bus.out_ready = 1'($urandom_range(0, 1));
        run++;
      end while (!frame_done && run < 400);
      check("rand_done", 32'(frame_done), 32'd1);
      check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    end
    check("max_outstanding", 32'(max_out), 32'd4);

    // frame_ready at pixel 3 queues one frame; a pulse in DONE starts one more.
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    d0 = done_cnt;
    push_frame();
    push_frame();
    pulse_frame();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.out_valid && bus.out_pixel_number == AW'(3)) && k < 50);
    check("pend_px3_seen", 32'(bus.out_pixel_number), 32'd3);
    frame_ready = 1'b1;
    @(posedge clk);
    #1 frame_ready = 1'b0;
    wait_done("pend_done1");
    wait_done("pend_done2");
    push_frame();
    frame_ready = 1'b1;
    @(posedge clk);
    #1 frame_ready = 1'b0;
    wait_done("pend_done3");
    repeat (10) @(negedge clk);
    check("pend_idle_after", 32'(busy), 32'd0);
    check("pend_queue_empty", 32'(exp_q.size()), 32'd0);
    check("pend_done_count", 32'(done_cnt - d0), 32'd3);

    // Reset mid-frame at pixel 5: immediate abandon, no stale returns afterwards.
    @(posedge clk);
    #1;
    push_frame();
    pulse_frame();
    d0 = done_cnt;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.out_valid && bus.out_pixel_number == AW'(5)) && k < 50);
    check("rst_px5_seen", 32'(bus.out_pixel_number), 32'd5);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pix", 32'(bus.out_pixel_number), 32'd0);
    check("mid_rst_rgb", {8'd0, bus.out_r, bus.out_g, bus.out_b}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("mid_rst_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    push_frame();
    pulse_frame();
    wait_done("post_rst_done");
    check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
